// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, issues imem word requests and
// queues returned instructions in order for decode, squashing wrong-path words.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_trgt_pc,
    input  logic        ex_jump,
    input  logic [31:0] ex_jump_trgt_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic        instr_addr_misaligned,
    output logic        halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0]   r_pc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_drop;
    logic [AW-1:0] r_qrd;
    logic [AW-1:0] r_qwr;
    logic [AW-1:0] r_trd;
    logic [AW-1:0] r_twr;
    logic [31:0]   r_tag  [DEPTH];
    logic [31:0]   r_qpc  [DEPTH];
    logic [31:0]   r_qdat [DEPTH];

    logic          w_active;
    logic          w_redirect;
    logic          w_misalign;
    logic [31:0]   w_target;
    logic [CW:0]   w_inuse;
    logic          w_req_fire;
    logic          w_rsp_fire;
    logic          w_push;
    logic          w_pop;

    assign w_active   = (r_state != ST_HALT);
    assign w_target   = ex_jump ? ex_jump_trgt_pc : ex_branch_trgt_pc;
    assign w_redirect = w_active & (ex_jump | ex_branch_taken);
    assign w_misalign = w_redirect & (w_target[1:0] != 2'b00);
    assign w_inuse    = {1'b0, r_out} + {1'b0, r_cnt};

    // Credit rule: every word in flight already owns a queue slot.
    assign imem_req_valid = ~rst & (r_state == ST_RUN) & ~w_redirect
                          & (w_inuse < LIMIT);
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;
    assign w_rsp_fire     = imem_rsp_valid;

    assign if_valid  = ~rst & w_active & (r_cnt != '0);
    assign if_pc     = r_qpc[r_qrd];
    assign if_instr  = r_qdat[r_qrd];
    assign w_pop     = if_valid & id_ready & ~w_redirect;
    assign w_push    = ~rst & w_rsp_fire & w_active & ~w_redirect
                     & (r_drop == '0);

    assign instr_addr_misaligned = ~rst & w_misalign;
    assign halted                = ~rst & (r_state == ST_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_INIT: w_state_nxt = w_misalign ? ST_HALT : ST_RUN;
            ST_RUN:  w_state_nxt = w_misalign ? ST_HALT : ST_RUN;
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_out  <= '0;
            r_cnt  <= '0;
            r_drop <= '0;
            r_qrd  <= '0;
            r_qwr  <= '0;
            r_trd  <= '0;
            r_twr  <= '0;
        end else begin
            r_out <= r_out + CW'(w_req_fire) - CW'(w_rsp_fire);
            if (w_req_fire) r_twr <= r_twr + AW'(1);
            if (w_rsp_fire) r_trd <= r_trd + AW'(1);
            if (w_redirect) begin
                // Everything still in flight after this cycle is wrong-path.
                r_drop <= r_out - CW'(w_rsp_fire);
                r_cnt  <= '0;
                r_qrd  <= '0;
                r_qwr  <= '0;
                if (!w_misalign) r_pc <= w_target;
            end else begin
                if (w_req_fire) r_pc <= r_pc + 32'd4;
                if (w_rsp_fire && r_drop != '0) r_drop <= r_drop - CW'(1);
                if (w_push) r_qwr <= r_qwr + AW'(1);
                if (w_pop)  r_qrd <= r_qrd + AW'(1);
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_fire) r_tag[r_twr] <= r_pc;
        if (w_push) begin
            r_qpc[r_qwr]  <= r_tag[r_trd];
            r_qdat[r_qwr] <= imem_rsp_data;
        end
    end

    a_no_rsp_underflow: assert property (
        @(posedge clk) disable iff (rst) imem_rsp_valid |-> (r_out != '0)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: queue-based reference model with an in-order imem
// model, directed scenarios pinned by literals, then randomized traffic.
module tb_if_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_trgt_pc;
    logic        ex_jump;
    logic [31:0] ex_jump_trgt_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        instr_addr_misaligned;
    logic        halted;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .imem_req_valid        (imem_req_valid),
        .imem_req_ready        (imem_req_ready),
        .imem_req_addr         (imem_req_addr),
        .imem_rsp_valid        (imem_rsp_valid),
        .imem_rsp_data         (imem_rsp_data),
        .ex_branch_taken       (ex_branch_taken),
        .ex_branch_trgt_pc     (ex_branch_trgt_pc),
        .ex_jump               (ex_jump),
        .ex_jump_trgt_pc       (ex_jump_trgt_pc),
        .if_valid              (if_valid),
        .if_instr              (if_instr),
        .if_pc                 (if_pc),
        .id_ready              (id_ready),
        .instr_addr_misaligned (instr_addr_misaligned),
        .halted                (halted)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          wrong;
    } inf_t;

    inf_t        iq[$];
    logic [31:0] mq_pc[$];
    logic [31:0] mq_d[$];
    bit          m_start;
    bit          m_halt;
    logic [31:0] m_pc;
    int          cyc;
    int          n_cmp;
    int          n_bad;

    bit          t_rst, t_rdy, t_idr, t_rok, t_j, t_b;
    logic [31:0] t_jt, t_bt;
    int          t_lat;

    logic [31:0] fire_log[$];
    logic [31:0] pop_log[$];
    int          pulse_cnt;
    int          reqv_cnt;
    bit          s_ifv, s_rqv, s_halt;

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        bit          redir, misal, erv, eiv, rsp, pop;
        logic [31:0] tgt;
        inf_t        e;
        @(negedge clk);
        rsp = !t_rst && iq.size() > 0 && iq[0].due <= cyc && t_rok;
        rst               = t_rst;
        imem_req_ready    = t_rdy;
        id_ready          = t_idr;
        imem_rsp_valid    = rsp;
        imem_rsp_data     = rsp ? fdat(iq[0].addr) : $urandom;
        ex_jump           = t_j;
        ex_jump_trgt_pc   = t_jt;
        ex_branch_taken   = t_b;
        ex_branch_trgt_pc = t_bt;
        #1;
        redir = !t_rst && (t_j || t_b) && !m_halt;
        tgt   = t_j ? t_jt : t_bt;
        misal = redir && (tgt[1:0] != 2'b00);
        erv   = !t_rst && m_start && !m_halt && !redir
              && (iq.size() + mq_pc.size() < DEPTH);
        eiv   = !t_rst && !m_halt && mq_pc.size() > 0;
        chk("req_valid", 32'(imem_req_valid), 32'(erv));
        chk("if_valid", 32'(if_valid), 32'(eiv));
        chk("misaligned", 32'(instr_addr_misaligned), 32'(misal));
        chk("halted", 32'(halted), 32'(m_halt && !t_rst));
        if (erv && imem_req_valid) chk("req_addr", imem_req_addr, m_pc);
        if (eiv && if_valid) begin
            chk("if_pc", if_pc, mq_pc[0]);
            chk("if_instr", if_instr, mq_d[0]);
        end
        s_ifv  = if_valid;
        s_rqv  = imem_req_valid;
        s_halt = halted;
        if (imem_req_valid && imem_req_ready) fire_log.push_back(imem_req_addr);
        if (if_valid && id_ready) pop_log.push_back(if_pc);
        if (instr_addr_misaligned) pulse_cnt++;
        if (imem_req_valid) reqv_cnt++;
        if (t_rst) begin
            iq.delete();
            mq_pc.delete();
            mq_d.delete();
            m_pc    = RPC;
            m_start = 0;
            m_halt  = 0;
        end else begin
            pop = eiv && t_idr && !redir;
            if (pop) begin
                void'(mq_pc.pop_front());
                void'(mq_d.pop_front());
            end
            if (rsp) begin
                e = iq.pop_front();
                if (!e.wrong && !m_halt && !redir) begin
                    mq_pc.push_back(e.addr);
                    mq_d.push_back(fdat(e.addr));
                end
            end
            if (redir) begin
                mq_pc.delete();
                mq_d.delete();
                foreach (iq[i]) iq[i].wrong = 1;
                if (misal) m_halt = 1;
                else m_pc = tgt;
            end
            if (erv && t_rdy) begin
                e.addr  = m_pc;
                e.due   = cyc + t_lat;
                e.wrong = 0;
                iq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
            m_start = 1;
        end
        cyc++;
    endtask

    task automatic do_reset(input int n);
        t_rst = 1;
        t_j   = 0;
        t_b   = 0;
        repeat (n) step();
        t_rst = 0;
        fire_log.delete();
        pop_log.delete();
    endtask

    initial begin
        int first;
        int wrong;
        logic [31:0] tg;
        n_cmp = 0; n_bad = 0; cyc = 0;
        m_pc = RPC; m_start = 0; m_halt = 0;
        t_rdy = 1; t_idr = 1; t_rok = 1; t_lat = 1;
        t_jt = 0; t_bt = 0; t_j = 0; t_b = 0;

        // 1: straight-line fetch after reset
        do_reset(3);
        first = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_ifv && first < 0) first = i;
        end
        chk("t1_first_ifv", 32'(first), 32'd3);
        chk("t1_req0", qat(fire_log, 0), 32'h0);
        chk("t1_req1", qat(fire_log, 1), 32'h4);
        chk("t1_req2", qat(fire_log, 2), 32'h8);
        chk("t1_pop0", qat(pop_log, 0), 32'h0);
        chk("t1_pop1", qat(pop_log, 1), 32'h4);
        chk("t1_pop2", qat(pop_log, 2), 32'h8);

        // 2: credit limit with decode stalled
        do_reset(2);
        t_lat = 3; t_idr = 0;
        repeat (15) step();
        chk("t2_nreq", 32'(fire_log.size()), 32'd4);
        chk("t2_req3", qat(fire_log, 3), 32'hC);
        chk("t2_reqv_idle", 32'(s_rqv), 32'd0);
        fire_log.delete();
        t_idr = 1;
        repeat (10) step();
        chk("t2_pop0", qat(pop_log, 0), 32'h0);
        chk("t2_pop1", qat(pop_log, 1), 32'h4);
        chk("t2_pop2", qat(pop_log, 2), 32'h8);
        chk("t2_pop3", qat(pop_log, 3), 32'hC);
        chk("t2_resume", qat(fire_log, 0), 32'h10);

        // 3: taken branch with two words in flight
        do_reset(2);
        t_lat = 5;
        for (int g = 0; g < 20 && fire_log.size() < 2; g++) step();
        chk("t3_setup", 32'(fire_log.size()), 32'd2);
        t_b = 1; t_bt = 32'h100;
        step();
        t_b = 0; t_lat = 1;
        fire_log.delete(); pop_log.delete();
        repeat (15) step();
        chk("t3_req", qat(fire_log, 0), 32'h100);
        chk("t3_pop", qat(pop_log, 0), 32'h100);
        wrong = 0;
        foreach (pop_log[i])
            if (pop_log[i] < 32'h100 || pop_log[i] >= 32'h200) wrong++;
        chk("t3_wrongpath", 32'(wrong), 32'd0);

        // 4: jump beats branch, concurrent response discarded
        do_reset(2);
        t_lat = 2;
        for (int g = 0; g < 10 && fire_log.size() < 1; g++) step();
        t_rdy = 0;
        for (int g = 0; g < 10; g++) begin
            if (iq.size() > 0 && iq[0].due <= cyc) break;
            step();
        end
        t_j = 1; t_jt = 32'h200; t_b = 1; t_bt = 32'h300;
        step();
        t_j = 0; t_b = 0; t_rdy = 1; t_lat = 1;
        fire_log.delete(); pop_log.delete();
        repeat (10) step();
        chk("t4_req", qat(fire_log, 0), 32'h200);
        chk("t4_pop", qat(pop_log, 0), 32'h200);

        // 5: misaligned jump halts fetch
        do_reset(2);
        repeat (4) step();
        pulse_cnt = 0; reqv_cnt = 0;
        t_j = 1; t_jt = 32'h102;
        step();
        t_j = 0;
        repeat (6) step();
        t_b = 1; t_bt = 32'h400;
        step();
        t_b = 0;
        repeat (3) step();
        chk("t5_pulses", 32'(pulse_cnt), 32'd1);
        chk("t5_halted", 32'(s_halt), 32'd1);
        chk("t5_reqv", 32'(reqv_cnt), 32'd0);
        chk("t5_ifv", 32'(s_ifv), 32'd0);

        // 6: reset with queue loaded and words outstanding
        do_reset(2);
        t_idr = 0; t_lat = 1;
        for (int g = 0; g < 20 && mq_pc.size() < 2; g++) step();
        t_lat = 10;
        for (int g = 0; g < 20 && iq.size() < 2; g++) step();
        chk("t6_setup", 32'(if_valid), 32'd1);
        t_rst = 1;
        step();
        t_rst = 0; t_idr = 1; t_lat = 1;
        fire_log.delete();
        step();
        chk("t6_ifv", 32'(s_ifv), 32'd0);
        chk("t6_halted", 32'(s_halt), 32'd0);
        repeat (4) step();
        chk("t6_pc", qat(fire_log, 0), RPC);

        // randomized traffic
        do_reset(2);
        for (int i = 0; i < 4000; i++) begin
            t_rst = ($urandom % 400 == 0) || (m_halt && $urandom % 20 == 0);
            t_rdy = ($urandom % 10) < 7;
            t_idr = ($urandom % 10) < 7;
            t_rok = ($urandom % 10) < 7;
            t_lat = 1 + int'($urandom % 4);
            t_j   = ($urandom % 40) == 0;
            t_b   = ($urandom % 30) == 0;
            tg    = $urandom & 32'hFFFF_FFFC;
            if ($urandom % 8 == 0) tg = 32'hFFFF_FFF4;
            if ($urandom % 12 == 0) tg = tg | 32'(1 + $urandom % 3);
            t_jt  = tg;
            t_bt  = $urandom & 32'hFFFF_FFFC;
            step();
        end
        t_rst = 0; t_j = 0; t_b = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
